fifo_rd_stream_adapter: RTL and testbench
=========================================

// Module: fifo_rd_stream_adapter
// PURPOSE
//  Read-side drain engine for custom_async_fifo; sits in the read clock domain.
//  - Pulls words from the FIFO read port (ren/empty/dout).
//  - Presents them downstream as a valid/ready stream, through a 2-entry skid buffer.
//  - Hides the FIFO's 1-cycle read latency; sustains 1 word/cycle.
// PARAMETERS
//  DATASIZE  8   data word width; must match the FIFO data width
//  CNTW      16  width of the transfer counter (only with FIFO_RD_CNT_EN)
// PORTS
//  clk_i         in   1         read clock (same clock as the FIFO rclk_i)
//  rst_n_i       in   1         asynchronous active-low reset
//  en_i          in   1         drain enable; 0 = issue no new FIFO reads
//  fifo_empty_i  in   1         FIFO empty flag
//  fifo_dout_i   in   DATASIZE  FIFO read data; valid in the cycle after ren is sampled
//  fifo_ren_o    out  1         FIFO read enable (combinational)
//  m_data_o      out  DATASIZE  stream data (head of buffer, registered)
//  m_valid_o     out  1         stream valid (registered: occ!=0)
//  m_ready_i     in   1         stream ready from downstream
//  occ_o         out  2         buffer occupancy, 0..2
//  xfer_cnt_o    out  CNTW      words accepted downstream (FIFO_RD_CNT_EN only)
// BEHAVIOUR
//  Reset (async, rst_n_i=0):
//  - occ=0, inflight=0, buffer=0.
//  - m_valid_o=0, m_data_o=0, occ_o=0, fifo_ren_o=0, xfer_cnt_o=0.
//  - A read issued before reset is discarded; its dout is not captured.
//  State:
//  - occ in {0,1,2}.
//  - inflight bit: set at the edge where ren is sampled; cleared at the next edge.
//  - No other FSM.
//  Pop: pop = m_valid_o && m_ready_i; the head is removed at the edge.
//  Read issue:
//  - fifo_ren_o = en_i && !fifo_empty_i && (occ + inflight - pop) < 2.
//  - The adapter never reads an empty FIFO.
//  - Capture can never overflow the 2-entry buffer.
//  Capture:
//  - When inflight=1, fifo_dout_i is written at the edge into slot (occ - pop).
//  - Pop and capture in the same edge: occ unchanged; slot1 shifts to slot0.
//  - Pop with no capture: occ-1. Capture with no pop: occ+1.
//  Latency:
//  - ren sampled at edge E1; dout captured at E2; m_valid_o high after E2.
//  - Two cycles from ren high to m_valid_o high.
//  Order: strict FIFO; no drop, no duplication.
//  Stream rules:
//  - m_data_o and m_valid_o stay stable while m_valid_o=1 and m_ready_i=0.
//  - m_valid_o never depends combinationally on m_ready_i.
//  Throughput: with occ=1, inflight=1, pop every cycle, ren stays high -> 1 word/cycle.
//  Backpressure: m_ready_i=0 for many cycles -> occ reaches 2, fifo_ren_o=0, FIFO holds.
//  en_i=0: no new ren; an in-flight word is still captured; the buffer still drains.
//  fifo_empty_i rising while inflight=1: the in-flight word is still captured.
// CONFIGURATION
//  FIFO_RD_CNT_EN defined:
//  - xfer_cnt_o increments by 1 on each pop.
//  - Wraps modulo 2**CNTW; async reset to 0.
//  FIFO_RD_CNT_EN undefined:
//  - xfer_cnt_o port and counter are absent.
//  - All other behaviour is identical.
// TESTING
//  1 Reset:
//    rst_n_i=0 mid-stream with occ=2 -> outputs 0 at once, no glitch on fifo_ren_o.
//    Post-reset data order restarts cleanly.
//  2 Single word:
//    FIFO holds 0xA5, m_ready_i=1 -> ren for 1 cycle; m_valid_o=1, m_data_o=0xA5
//    two cycles later; occ_o back to 0.
//  3 Stream:
//    push 460 random bytes through the FIFO, m_ready_i=1 -> all 460 out in order.
//    Steady state ren=1 every cycle; xfer_cnt_o=460.
//  4 Backpressure:
//    FIFO holds 0x01..0x05, m_ready_i=0 -> occ_o=2, data 0x01 held stable.
//    Exactly 2 reads issued; release ready -> 0x01..0x05 in order.
//  5 Enable gating:
//    en_i=0 with a non-empty FIFO -> fifo_ren_o=0.
//    Drop en_i in the same cycle as a ren -> the in-flight word is still delivered.
//  6 Counter wrap (FIFO_RD_CNT_EN, CNTW=4):
//    17 pops -> xfer_cnt_o=1.
//    Build without the macro -> compiles; tests 1-5 pass.

Source files
------------

// File: rtl/fifo_rd_stream_adapter.sv
// ---------------------------------------------------------------------------
// fifo_rd_stream_adapter
//
// Read-side drain engine for custom_async_fifo, running in the FIFO read clock
// domain. It pulls words from the FIFO read port and presents them downstream
// as a valid/ready stream through a 2-entry skid buffer. The buffer absorbs
// the FIFO's 1-cycle read latency, so 1 word/cycle is sustained with
// m_ready_i held high.
//
// Optional feature macro: FIFO_RD_CNT_EN
//   defined   -> xfer_cnt_o counts accepted words (wraps modulo 2**CNTW)
//   undefined -> xfer_cnt_o port and counter are absent
//
// Ports
//   clk_i         in   read clock (same as FIFO rclk_i)
//   rst_n_i       in   asynchronous active-low reset
//   en_i          in   drain enable; 0 stops new FIFO reads
//   fifo_empty_i  in   FIFO empty flag
//   fifo_dout_i   in   FIFO read data, valid the cycle after ren is sampled
//   fifo_ren_o    out  FIFO read enable (combinational)
//   m_data_o      out  stream data, head of the buffer (registered)
//   m_valid_o     out  stream valid, buffer non-empty (registered)
//   m_ready_i     in   stream ready from downstream
//   occ_o         out  buffer occupancy 0..2
//   xfer_cnt_o    out  words accepted downstream (FIFO_RD_CNT_EN only)
// ---------------------------------------------------------------------------
module fifo_rd_stream_adapter #(
   parameter int DATASIZE = 8,
   parameter int CNTW     = 16
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                en_i,
   input  logic                fifo_empty_i,
   input  logic [DATASIZE-1:0] fifo_dout_i,
   output logic                fifo_ren_o,
   output logic [DATASIZE-1:0] m_data_o,
   output logic                m_valid_o,
   input  logic                m_ready_i,
   output logic [1:0]          occ_o
`ifdef FIFO_RD_CNT_EN
   ,
   output logic [CNTW-1:0]     xfer_cnt_o
`endif
);

   if (DATASIZE < 1 || CNTW < 1) begin : g_param_check
      $error("fifo_rd_stream_adapter: DATASIZE and CNTW must be >= 1");
   end

   logic [1:0]          occ_q, occ_d;
   logic                inflight_q;
   logic                valid_q;
   logic [DATASIZE-1:0] slot0_q, slot0_d;
   logic [DATASIZE-1:0] slot1_q, slot1_d;
   logic                pop;
   logic [2:0]          level;

   assign pop = valid_q & m_ready_i;

   // Committed words after this edge, excluding a read issued now.
   // Never underflows: pop implies occ >= 1.
   assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

   // Gated by rst_n_i so no read is requested while reset is asserted.
   assign fifo_ren_o = rst_n_i & en_i & ~fifo_empty_i & (level < 3'd2);

   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      occ_d   = occ_q;
      if (pop) begin
         slot0_d = slot1_q;
         occ_d   = occ_q - 2'd1;
      end
      // The returning word lands in the first free slot after the pop.
      if (inflight_q) begin
         if (occ_d == 2'd0) begin
            slot0_d = fifo_dout_i;
         end else begin
            slot1_d = fifo_dout_i;
         end
         occ_d = occ_d + 2'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         valid_q    <= 1'b0;
         slot0_q    <= '0;
         slot1_q    <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= fifo_ren_o;
         valid_q    <= (occ_d != 2'd0);
         slot0_q    <= slot0_d;
         slot1_q    <= slot1_d;
      end
   end

   assign m_data_o  = slot0_q;
   assign m_valid_o = valid_q;
   assign occ_o     = occ_q;

`ifdef FIFO_RD_CNT_EN
   logic [CNTW-1:0] xfer_cnt_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         xfer_cnt_q <= '0;
      end else if (pop) begin
         xfer_cnt_q <= xfer_cnt_q + CNTW'(1);
      end
   end

   assign xfer_cnt_o = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
module tb_fifo_rd_stream_adapter;

   localparam int DW = 8;
`ifdef FIFO_RD_CNT_EN
   localparam int CNTW = 4;
`else
   localparam int CNTW = 16;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          fifo_empty;
   logic [DW-1:0] fifo_dout;
   logic          fifo_ren;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic [1:0]    occ;
`ifdef FIFO_RD_CNT_EN
   logic [CNTW-1:0] xfer_cnt;
`endif

   always #5 clk = ~clk;

   fifo_rd_stream_adapter #(.DATASIZE(DW), .CNTW(CNTW)) dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .en_i         (en),
      .fifo_empty_i (fifo_empty),
      .fifo_dout_i  (fifo_dout),
      .fifo_ren_o   (fifo_ren),
      .m_data_o     (m_data),
      .m_valid_o    (m_valid),
      .m_ready_i    (m_ready),
      .occ_o        (occ)
`ifdef FIFO_RD_CNT_EN
      ,
      .xfer_cnt_o   (xfer_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] fq[$];     // contents of the modelled FIFO
   logic [DW-1:0] exp_q[$];  // scoreboard: words expected downstream, in order

   int   rd_total  = 0;      // reads accepted by the FIFO model
   int   cap_total = 0;      // words that have reached the buffer
   int   pop_total = 0;      // words accepted downstream since reset
   logic rd_pend   = 1'b0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data  = '0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
      end
   endtask

   // FIFO read port model: data appears the cycle after ren is sampled.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_pend   <= 1'b0;
         cap_total <= 0;
         fifo_dout <= '0;
      end else begin
         if (rd_pend) cap_total <= cap_total + 1;
         rd_pend <= fifo_ren;
         if (fifo_ren) begin
            rd_total <= rd_total + 1;
            if (fq.size() > 0) fifo_dout <= fq.pop_front();
            fifo_empty <= (fq.size() == 0);
         end
      end
   end

   // Monitor: sample mid-cycle, the values the next rising edge will use.
   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (!rst_n) begin
         pop_total  = 0;
         prev_stall = 1'b0;
      end else begin
         chk("occ", 32'(occ), 32'(cap_total - pop_total));
         chk("valid", 32'(m_valid), 32'(cap_total != pop_total));
         chk("ren_on_empty", 32'(fifo_ren & fifo_empty), 32'd0);
`ifdef FIFO_RD_CNT_EN
         chk("xfer_cnt", 32'(xfer_cnt), 32'(pop_total % (1 << CNTW)));
`endif
         if (prev_stall) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", 32'(m_data), 32'(prev_data));
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word got %0h want none", m_data);
            end else begin
               e = exp_q.pop_front();
               chk("data", 32'(m_data), 32'(e));
            end
            pop_total++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [DW-1:0] b);
      fq.push_back(b);
      exp_q.push_back(b);
      fifo_empty <= 1'b0;
   endtask

   task automatic drain(input int max_cyc);
      int k = 0;
      while ((exp_q.size() != 0 || fq.size() != 0) && k < max_cyc) begin
         cyc(1);
         k++;
      end
      chk("drain_done", 32'(exp_q.size() + fq.size()), 32'd0);
   endtask

   initial begin
      int r0, p0, k;
      rst_n      = 1'b0;
      en         = 1'b1;
      m_ready    = 1'b0;
      fifo_empty <= 1'b0;   // would request a read if reset did not gate it
      #3;
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_data", 32'(m_data), 32'd0);
      chk("rst_occ", 32'(occ), 32'd0);
      chk("rst_ren", 32'(fifo_ren), 32'd0);
      fifo_empty <= 1'b1;
      cyc(2);
      rst_n = 1'b1;
      cyc(2);

      // Single word: valid two cycles after ren.
      m_ready = 1'b1;
      push(8'hA5);
      @(negedge clk);
      chk("t2_ren_high", 32'(fifo_ren), 32'd1);
      cyc(1);
      @(negedge clk);
      chk("t2_ren_low", 32'(fifo_ren), 32'd0);
      chk("t2_valid_e1", 32'(m_valid), 32'd0);
      cyc(1);
      @(negedge clk);
      chk("t2_valid_e2", 32'(m_valid), 32'd1);
      chk("t2_data", 32'(m_data), 32'hA5);
      cyc(1);
      @(negedge clk);
      chk("t2_occ_end", 32'(occ), 32'd0);
      cyc(1);

      // Backpressure: exactly two reads, head held.
      m_ready = 1'b0;
      r0 = rd_total;
      for (int i = 1; i <= 5; i++) push(8'(i));
      cyc(8);
      @(negedge clk);
      chk("t4_occ", 32'(occ), 32'd2);
      chk("t4_head", 32'(m_data), 32'h01);
      chk("t4_reads", 32'(rd_total - r0), 32'd2);
      chk("t4_ren", 32'(fifo_ren), 32'd0);
      cyc(1);
      m_ready = 1'b1;
      drain(50);

      // Enable gating and an in-flight word across en drop.
      en = 1'b0;
      r0 = rd_total;
      for (int i = 0; i < 3; i++) push(8'($urandom));
      cyc(3);
      @(negedge clk);
      chk("t5_ren_gated", 32'(fifo_ren), 32'd0);
      chk("t5_no_reads", 32'(rd_total - r0), 32'd0);
      cyc(1);
      p0 = pop_total;
      en = 1'b1;
      @(negedge clk);
      chk("t5_ren_on", 32'(fifo_ren), 32'd1);
      cyc(1);
      en = 1'b0;
      cyc(4);
      @(negedge clk);
      chk("t5_one_read", 32'(rd_total - r0), 32'd1);
      chk("t5_delivered", 32'(pop_total - p0), 32'd1);
      chk("t5_fifo_left", 32'(fq.size()), 32'd2);
      cyc(1);
      en = 1'b1;
      drain(50);

      // Stream of 460 words at full rate.
      p0 = pop_total;
      for (int i = 0; i < 460; i++) push(8'($urandom));
      k = 0;
      while (k < 1000) begin
         @(negedge clk);
         if (fq.size() == 0) break;
         chk("t3_steady_ren", 32'(fifo_ren), 32'd1);
         k++;
      end
      cyc(1);
      drain(50);
      chk("t3_count", 32'(pop_total - p0), 32'd460);

      // Reset mid-stream with a full buffer.
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(8'($urandom));
      cyc(6);
      @(negedge clk);
      chk("t1_occ_full", 32'(occ), 32'd2);
      cyc(1);
      rst_n = 1'b0;
      #1;
      chk("t1_valid", 32'(m_valid), 32'd0);
      chk("t1_data", 32'(m_data), 32'd0);
      chk("t1_occ", 32'(occ), 32'd0);
      chk("t1_ren", 32'(fifo_ren), 32'd0);
      fq.delete();
      exp_q.delete();
      fifo_empty <= 1'b1;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);

      // Post-reset restart, 17 pops (counter wraps when CNTW=4).
      m_ready = 1'b1;
      for (int i = 0; i < 17; i++) push(8'($urandom));
      drain(100);
      cyc(2);
      chk("t6_pops", 32'(pop_total), 32'd17);
`ifdef FIFO_RD_CNT_EN
      chk("t6_cnt_wrap", 32'(xfer_cnt), 32'd1);
`endif

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         m_ready = ($urandom_range(0, 3) != 0);
         en      = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 2) == 0 && fq.size() < 20) push(8'($urandom));
         cyc(1);
      end
      en      = 1'b1;
      m_ready = 1'b1;
      drain(200);
      cyc(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
